io_regs_pulse: RTL and testbench

IO_REGS_PULSE -- requirements
Module: io_regs_pulse

---
 rtl/io_regs_pulse_if.sv | 10 +
 rtl/io_regs_pulse.sv | 167 ++++++++++++++++
 tb/tb_io_regs_pulse.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_regs_pulse_if.sv
// Serial register-write bus: 7-bit address, 32-bit data, one-cycle strobe qualifier.
// No latency of its own; there is no backpressure, so every strobe is taken.
interface io_regs_pulse_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (output serial_addr, serial_data, serial_strobe);
  modport slave  (input  serial_addr, serial_data, serial_strobe);
endinterface

// File: rtl/io_regs_pulse.sv
// Four 16-bit masked-write pin banks plus a timed XOR pulse; IO_CHANGE_DETECT_EN adds input-change flags.
// Latency: 1 clock from the strobe to reg_k. Change flags set 3 clocks after an io_in edge.
// Backpressure: none. A pulse request made while busy is dropped and sets pulse_overrun.
module io_regs_pulse #(
  parameter logic [6:0] ADDR_BASE = 7'd64
) (
  input  logic            clock,
  input  logic            reset_n,
  io_regs_pulse_if.slave  bus,
  output logic [15:0]     reg_0,
  output logic [15:0]     reg_1,
  output logic [15:0]     reg_2,
  output logic [15:0]     reg_3,
  output logic            pulse_busy,
  output logic            pulse_overrun,
  input  logic [63:0]     io_in,
  output logic [63:0]     change_flags
);

  localparam logic [6:0] ADDR_PULSE = ADDR_BASE + 7'd4;
  localparam logic [6:0] ADDR_LEN   = ADDR_BASE + 7'd5;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] mask_q, mask_d;
  logic [1:0]  bank_q, bank_d;
  logic        ovr_q, ovr_d;
  logic [15:0] base_q [4];
  logic [15:0] base_d [4];
  logic [15:0] reg_q  [4];
  logic [15:0] reg_d  [4];

  logic pulse_wr;
  logic len_wr;

  assign pulse_wr = bus.serial_strobe && (bus.serial_addr == ADDR_PULSE);
  assign len_wr   = bus.serial_strobe && (bus.serial_addr == ADDR_LEN);

  // Bit-masked base update: data[31:16] selects which bits take data[15:0].
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      base_d[k] = base_q[k];
      if (bus.serial_strobe && (bus.serial_addr == ADDR_BASE + 7'(k)))
        base_d[k] = (base_q[k] & ~bus.serial_data[31:16])
                  | (bus.serial_data[15:0] & bus.serial_data[31:16]);
    end
  end

  always_comb begin
    len_d = len_q;
    if (len_wr)
      len_d = bus.serial_data[15:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (pulse_wr && (len_q != 16'd0)) begin
          state_d = ACTIVE;
          cnt_d   = len_q;
          mask_d  = bus.serial_data[15:0];
          bank_d  = bus.serial_data[17:16];
        end
      end
      ACTIVE: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear and an overrun in the same write resolve to set.
  always_comb begin
    ovr_d = ovr_q;
    if (pulse_wr) begin
      if (bus.serial_data[31])
        ovr_d = 1'b0;
      if (state_q == ACTIVE)
        ovr_d = 1'b1;
    end
  end

  // Outputs are built from next-state values so the toggle window matches busy exactly.
  always_comb begin
    for (int k = 0; k < 4; k++)
      reg_d[k] = base_d[k] ^ (((state_d == ACTIVE) && (bank_d == 2'(k))) ? mask_d : 16'h0000);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      bank_q  <= '0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        base_q[k] <= '0;
        reg_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      bank_q  <= bank_d;
      ovr_q   <= ovr_d;
      for (int k = 0; k < 4; k++) begin
        base_q[k] <= base_d[k];
        reg_q[k]  <= reg_d[k];
      end
    end
  end

  assign reg_0         = reg_q[0];
  assign reg_1         = reg_q[1];
  assign reg_2         = reg_q[2];
  assign reg_3         = reg_q[3];
  assign pulse_busy    = (state_q == ACTIVE);
  assign pulse_overrun = ovr_q;

`ifdef IO_CHANGE_DETECT_EN
  localparam logic [6:0] ADDR_CLR = ADDR_BASE + 7'd6;

  logic [63:0] sync1_q, sync2_q, sync3_q;
  logic [63:0] flags_q, flags_d;
  logic [63:0] clr_bits;

  // A fresh change in the clearing cycle must survive, hence clear-then-set.
  always_comb begin
    clr_bits = '0;
    if (bus.serial_strobe && (bus.serial_addr == ADDR_CLR))
      clr_bits[{bus.serial_data[17:16], 4'b0000} +: 16] = bus.serial_data[15:0];
    flags_d = (flags_q & ~clr_bits) | (sync2_q ^ sync3_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      flags_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      flags_q <= flags_d;
    end
  end

  assign change_flags = flags_q;
`else
  logic unused_io_in;
  assign unused_io_in = ^io_in;
  assign change_flags = '0;
`endif

endmodule

// File: tb/tb_io_regs_pulse.sv
// Bench for io_regs_pulse: directed vector table, corner sequences, then random traffic against a reference model.
module tb_io_regs_pulse;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] reg_0, reg_1, reg_2, reg_3;
  logic        pulse_busy, pulse_overrun;
  logic [63:0] io_in, change_flags;

  always #5 clock = ~clock;

  io_regs_pulse_if bus ();

  io_regs_pulse #(.ADDR_BASE(7'd64)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .bus           (bus),
    .reg_0         (reg_0),
    .reg_1         (reg_1),
    .reg_2         (reg_2),
    .reg_3         (reg_3),
    .pulse_busy    (pulse_busy),
    .pulse_overrun (pulse_overrun),
    .io_in         (io_in),
    .change_flags  (change_flags)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the pulse is "m_rem more clocks of toggled output".
  logic [15:0] m_base [4];
  logic [15:0] m_len, m_mask;
  logic [1:0]  m_bank;
  logic        m_ovr;
  int          m_rem;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    logic        strobe;
    logic [63:0] e_regs;
    logic        e_busy;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [63:0] pk(logic [15:0] r0, logic [15:0] r1, logic [15:0] r2, logic [15:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic vec_t mk(logic [6:0] a, logic [31:0] d, logic s, logic [63:0] er, logic eb);
    vec_t v;
    v.addr = a; v.data = d; v.strobe = s; v.e_regs = er; v.e_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_base[k] = '0;
    m_len = '0; m_mask = '0; m_bank = '0; m_ovr = 1'b0; m_rem = 0;
  endtask

  function automatic logic [15:0] m_reg(int k);
    return m_base[k] ^ (((m_rem > 0) && (m_bank == 2'(k))) ? m_mask : 16'h0000);
  endfunction

  task automatic model_edge(input logic [6:0] a, input logic [31:0] d, input logic s);
    bit busy_before;
    busy_before = (m_rem > 0);
    if (m_rem > 0) m_rem--;
    if (s) begin
      for (int k = 0; k < 4; k++)
        if (a == 7'(64 + k))
          m_base[k] = (m_base[k] & ~d[31:16]) | (d[15:0] & d[31:16]);
      if (a == 7'd69) m_len = d[15:0];
      if (a == 7'd68) begin
        if (d[31]) m_ovr = 1'b0;
        if (busy_before) m_ovr = 1'b1;
        else if (m_len != 16'd0) begin
          m_rem  = int'(m_len);
          m_mask = d[15:0];
          m_bank = d[17:16];
        end
      end
    end
  endtask

  // Drive at the negedge, let the posedge act, return at the next negedge for sampling.
  task automatic cycle(input logic [6:0] a, input logic [31:0] d, input logic s);
    bus.serial_addr   = a;
    bus.serial_data   = d;
    bus.serial_strobe = s;
    @(posedge clock);
    model_edge(a, d, s);
    @(negedge clock);
    bus.serial_strobe = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check($sformatf("%s reg_0", tag), reg_0, m_reg(0));
    check($sformatf("%s reg_1", tag), reg_1, m_reg(1));
    check($sformatf("%s reg_2", tag), reg_2, m_reg(2));
    check($sformatf("%s reg_3", tag), reg_3, m_reg(3));
    check($sformatf("%s busy", tag), pulse_busy, m_rem > 0);
    check($sformatf("%s overrun", tag), pulse_overrun, m_ovr);
    check($sformatf("%s change_flags", tag), change_flags, 64'h0);
  endtask

  initial begin
    logic [6:0]  ra;
    logic [31:0] rd;
    logic        rs;
    bit          seen;

    vecs[0]  = mk(7'd65, 32'hFF00_AB00, 1'b1, pk(16'h0, 16'hAB00, 16'h0, 16'h0), 1'b0);
    vecs[1]  = mk(7'd65, 32'h00FF_00CD, 1'b1, pk(16'h0, 16'hABCD, 16'h0, 16'h0), 1'b0);
    vecs[2]  = mk(7'd65, 32'hFFFF_0000, 1'b0, pk(16'h0, 16'hABCD, 16'h0, 16'h0), 1'b0);
    vecs[3]  = mk(7'd71, 32'hFFFF_FFFF, 1'b1, pk(16'h0, 16'hABCD, 16'h0, 16'h0), 1'b0);
    vecs[4]  = mk(7'd63, 32'hFFFF_FFFF, 1'b1, pk(16'h0, 16'hABCD, 16'h0, 16'h0), 1'b0);
    vecs[5]  = mk(7'd70, 32'hFFFF_FFFF, 1'b1, pk(16'h0, 16'hABCD, 16'h0, 16'h0), 1'b0);
    vecs[6]  = mk(7'd69, 32'h0000_0005, 1'b1, pk(16'h0, 16'hABCD, 16'h0, 16'h0), 1'b0);
    vecs[7]  = mk(7'd68, 32'h0002_0001, 1'b1, pk(16'h0, 16'hABCD, 16'h1, 16'h0), 1'b1);
    for (int i = 8; i < 12; i++)
      vecs[i] = mk(7'd0, 32'h0, 1'b0, pk(16'h0, 16'hABCD, 16'h1, 16'h0), 1'b1);
    vecs[12] = mk(7'd0, 32'h0, 1'b0, pk(16'h0, 16'hABCD, 16'h0, 16'h0), 1'b0);

    reset_n = 1'b0;
    io_in = '0;
    bus.serial_addr = '0; bus.serial_data = '0; bus.serial_strobe = 1'b0;
    model_reset();
    #3;
    check("reset regs", {reg_3, reg_2, reg_1, reg_0}, 64'h0);
    check("reset busy", pulse_busy, 1'b0);
    check("reset overrun", pulse_overrun, 1'b0);
    check("reset change_flags", change_flags, 64'h0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    check_model("post-reset");

    // Masked writes, ignored addresses, 5-clock pulse on bank 2
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].addr, vecs[i].data, vecs[i].strobe);
      check($sformatf("vec%0d regs", i), {reg_3, reg_2, reg_1, reg_0}, vecs[i].e_regs);
      check($sformatf("vec%0d busy", i), pulse_busy, vecs[i].e_busy);
    end

    // Overrun during a pulse, clear-vs-set, then clear in idle with zero length
    cycle(7'd68, 32'h0003_0003, 1'b1);
    check("ovr start reg_3", reg_3, 16'h0003);
    cycle(7'd0, 32'h0, 1'b0);
    cycle(7'd68, 32'h8000_FFFF, 1'b1);
    check("ovr set wins", pulse_overrun, 1'b1);
    check("ovr reg_0 untouched", reg_0, 16'h0000);
    check("ovr reg_3 unchanged", reg_3, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      cycle(7'd0, 32'h0, 1'b0);
      check_model($sformatf("ovr tail%0d", i));
    end
    check("ovr pulse ended", pulse_busy, 1'b0);
    check("ovr reg_3 restored", reg_3, 16'h0000);
    cycle(7'd69, 32'h0, 1'b1);
    cycle(7'd68, 32'h8000_0000, 1'b1);
    check("ovr cleared", pulse_overrun, 1'b0);
    check("ovr clear no pulse", pulse_busy, 1'b0);
    cycle(7'd68, 32'h0001_FFFF, 1'b1);
    check("zero len no toggle", reg_1, 16'hABCD);
    check("zero len not busy", pulse_busy, 1'b0);

    // Base rewrite in the middle of a 10-clock pulse on bank 0
    cycle(7'd69, 32'h0000_000A, 1'b1);
    cycle(7'd68, 32'h0000_00F0, 1'b1);
    check("mid c1 reg_0", reg_0, 16'h00F0);
    cycle(7'd0, 32'h0, 1'b0);
    cycle(7'd64, 32'hFFFF_1234, 1'b1);
    check("mid c3 reg_0", reg_0, 16'h12C4);
    for (int i = 4; i <= 10; i++) begin
      cycle(7'd0, 32'h0, 1'b0);
      check($sformatf("mid c%0d reg_0", i), reg_0, 16'h12C4);
    end
    cycle(7'd0, 32'h0, 1'b0);
    check("mid end reg_0", reg_0, 16'h1234);
    check("mid end busy", pulse_busy, 1'b0);

    // Asynchronous reset two clocks into an 8-clock pulse
    cycle(7'd69, 32'h0000_0008, 1'b1);
    cycle(7'd68, 32'h0001_FFFF, 1'b1);
    check("rst pulse reg_1", reg_1, 16'h5432);
    cycle(7'd0, 32'h0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rst async regs", {reg_3, reg_2, reg_1, reg_0}, 64'h0);
    check("rst async busy", pulse_busy, 1'b0);
    model_reset();
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(7'd0, 32'h0, 1'b0);
      check_model($sformatf("rst after%0d", i));
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      ra = (($urandom_range(0, 9)) < 8) ? 7'(64 + $urandom_range(0, 7)) : 7'($urandom);
      rd = $urandom;
      if (ra == 7'd69) rd = 32'($urandom_range(0, 7));
      rs = ($urandom_range(0, 3) != 0);
      cycle(ra, rd, rs);
      check_model($sformatf("rand%0d", i));
    end

`ifdef IO_CHANGE_DETECT_EN
    io_in[17] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      cycle(7'd0, 32'h0, 1'b0);
      seen = change_flags[17];
    end
    check("chg flag set", {63'h0, seen}, 64'h1);
    cycle(7'd70, 32'h0001_0002, 1'b1);
    check("chg flag cleared", change_flags, 64'h0);
`else
    seen = 1'b0;
    io_in = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      cycle(7'd0, 32'h0, 1'b0);
      seen = seen | (|change_flags);
    end
    check("no chg detect", {63'h0, seen}, 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
